vx_mem_tag_compactor: RTL
=========================

// Module: VX_mem_tag_compactor
// PURPOSE
//  Sits between the cache cluster's per-port memory bus and the platform memory interface.
//  Maps the wide cache/bypass memory tag (IN_TAG_WIDTH) to a compact ID (OUT_TAG_WIDTH).
//  On each read, allocates a table entry, forwards the read with entry index as tag, and
//  restores the original tag on the response. Writes are fire-and-forget and bypass the table.
// PARAMETERS
//  NUM_ENTRIES   16   outstanding read capacity; power of 2, >=2
//  ADDR_WIDTH    26   line-address width
//  DATA_SIZE     64   line size, bytes
//  IN_TAG_WIDTH  12   upstream tag width
//  OUT_TAG_WIDTH `CLOG2(NUM_ENTRIES), derived; downstream tag width
// PORTS
//  clk              in   1            clock
//  reset            in   1            synchronous, active-high
//  in_req_valid     in   1            upstream request valid
//  in_req_rw        in   1            1=write, 0=read
//  in_req_addr      in   ADDR_WIDTH   line address
//  in_req_data      in   DATA_SIZE*8  write data
//  in_req_byteen    in   DATA_SIZE    byte enables
//  in_req_tag       in   IN_TAG_WIDTH original tag
//  in_req_ready     out  1            upstream request accepted
//  out_req_valid/rw/addr/data/byteen  out  (same widths)  downstream request
//  out_req_tag      out  OUT_TAG_WIDTH compact tag
//  out_req_ready    in   1            downstream accept
//  mem_rsp_valid    in   1            downstream read response valid
//  mem_rsp_data     in   DATA_SIZE*8  response data
//  mem_rsp_tag      in   OUT_TAG_WIDTH compact tag of response
//  mem_rsp_ready    out  1            response accepted
//  in_rsp_valid/data out (same)       upstream response
//  in_rsp_tag       out  IN_TAG_WIDTH restored tag
//  in_rsp_ready     in   1            upstream accepts response
//  pending_count    out  OUT_TAG_WIDTH+1  allocated entries
//  err_unalloc      out  1            sticky: response hit a free entry
// BEHAVIOUR
//  Reset
//   - All entries free; pending_count=0; err_unalloc=0.
//   - Request path holds no register; out_req_valid=0 follows from in_req_valid=0.
//  Request path: combinational, 0 latency
//   - Read: out_req_valid = in_req_valid & has_free; out_req_tag = lowest free index.
//   - Read: in_req_ready = out_req_ready & has_free.
//   - Write: out_req_valid = in_req_valid; in_req_ready = out_req_ready; out_req_tag = 0.
//   - Write: no allocation, and writes are never blocked by a full table.
//  Allocation
//   - On read fire (in_req_valid & in_req_ready), next edge: entry's valid bit set
//     and tag_table[idx] = in_req_tag.
//  Response path: combinational, 0 latency
//   - in_rsp_valid = mem_rsp_valid & valid[mem_rsp_tag]; in_rsp_tag = tag_table[mem_rsp_tag].
//   - mem_rsp_ready = in_rsp_ready | ~valid[mem_rsp_tag].
//   - On response fire with entry valid, next edge: entry freed.
//   - Response to a free entry: consumed, dropped; err_unalloc set until reset.
//  Simultaneous alloc + free
//   - Both are applied; pending_count is unchanged.
//   - The entry freed this cycle is not allocatable until the next cycle
//     (free list is read from registered state only).
//  Full: with NUM_ENTRIES allocated, reads stall (in_req_ready=0) until a free occurs.
//  Ordering: out-of-order responses supported; no ordering between reads and writes.
//  Invariant: pending_count == popcount(valid); never exceeds NUM_ENTRIES.
//  Reset mid-operation: all entries dropped; late responses after reset set err_unalloc.
// CONFIGURATION
//  MEM_TAG_COMPACT_PERF_EN defined: adds two outputs, both cleared by reset, saturating.
//   - perf_stall_cycles [31:0]: counts cycles with a read pending and no free entry.
//   - perf_peak_pending: max pending_count since reset.
//  Undefined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  VX_gpu_pkg holds mem_tag_compact_perf_t {stall_cycles, peak_pending}.
//  Sub-module VX_tag_alloc: valid-bit vector, lowest-index priority encoder,
//  alloc/free ports, full/count outputs. Tag table stays in the top level.
// TESTING
//  1. Reset, read tag 0xABC -> out_req_tag=0; rsp tag 0 -> in_rsp_tag=0xABC; pending 1->0.
//  2. 16 reads, no responses -> in_req_ready=0 on 17th read; a write that cycle still
//     fires with out_req_tag=0.
//  3. Full table, free tag 5 while a read waits -> read issues next cycle with tag 5,
//     not the same cycle.
//  4. Respond in order 3,0,2,1 to four reads -> each restored tag matches its request.
//  5. mem_rsp_tag=7 while entry 7 free -> mem_rsp_ready=1, in_rsp_valid=0, err_unalloc=1.
//  6. Alloc and free same edge at pending=4 -> pending stays 4. With
//     MEM_TAG_COMPACT_PERF_EN: full for 10 cycles with a read waiting ->
//     perf_stall_cycles=10, perf_peak_pending=16.

Source files
------------

// File: rtl/vx_mem_tag_compactor_pkg.sv
// Shared types for the memory tag compactor.
// Optional MEM_TAG_COMPACT_PERF_EN build uses mem_tag_compact_perf_t.
package vx_mem_tag_compactor_pkg;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    localparam int PERF_W = 32;

    typedef struct packed {
        logic [PERF_W-1:0] stall_cycles;
        logic [PERF_W-1:0] peak_pending;
    } mem_tag_compact_perf_t;

endpackage

// File: rtl/vx_mem_tag_compactor_tag_alloc.sv
// Entry allocator: valid-bit vector, lowest-free priority encoder,
// allocation/free ports and an occupancy counter.
module vx_mem_tag_compactor_tag_alloc #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alloc_en,
    input  logic         free_en,
    input  logic [W-1:0] free_idx,
    output logic [N-1:0] valid,
    output logic [W-1:0] alloc_idx,
    output logic         full,
    output logic [W:0]   count
);

    logic         has_free;
    logic         alloc_ok;
    logic         free_ok;
    logic [N-1:0] valid_n;

    always_comb begin
        alloc_idx = '0;
        has_free  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_idx = W'(i);
                has_free  = 1'b1;
            end
        end
    end

    assign full     = ~has_free;
    assign alloc_ok = alloc_en & has_free;
    assign free_ok  = free_en & valid[free_idx];

    // The freed slot is still set in registered state, so it never
    // collides with alloc_idx in the same cycle.
    always_comb begin
        valid_n = valid;
        if (free_ok)
            valid_n[free_idx] = 1'b0;
        if (alloc_ok)
            valid_n[alloc_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= valid_n;
            count <= count + (W + 1)'(alloc_ok) - (W + 1)'(free_ok);
        end
    end

endmodule

// File: rtl/vx_mem_tag_compactor.sv
// Compacts wide upstream read tags to table indices and restores them on response.
// Define MEM_TAG_COMPACT_PERF_EN to add stall/peak performance counters.
module vx_mem_tag_compactor
    import vx_mem_tag_compactor_pkg::*;
#(
    parameter int NUM_ENTRIES   = 16,
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_SIZE     = 64,
    parameter int IN_TAG_WIDTH  = 12,
    parameter int OUT_TAG_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef MEM_TAG_COMPACT_PERF_EN
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_peak_pending,
`endif
    input  logic                     in_req_valid,
    input  logic                     in_req_rw,
    input  logic [ADDR_WIDTH-1:0]    in_req_addr,
    input  logic [DATA_SIZE*8-1:0]   in_req_data,
    input  logic [DATA_SIZE-1:0]     in_req_byteen,
    input  logic [IN_TAG_WIDTH-1:0]  in_req_tag,
    output logic                     in_req_ready,
    output logic                     out_req_valid,
    output logic                     out_req_rw,
    output logic [ADDR_WIDTH-1:0]    out_req_addr,
    output logic [DATA_SIZE*8-1:0]   out_req_data,
    output logic [DATA_SIZE-1:0]     out_req_byteen,
    output logic [OUT_TAG_WIDTH-1:0] out_req_tag,
    input  logic                     out_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [DATA_SIZE*8-1:0]   mem_rsp_data,
    input  logic [OUT_TAG_WIDTH-1:0] mem_rsp_tag,
    output logic                     mem_rsp_ready,
    output logic                     in_rsp_valid,
    output logic [DATA_SIZE*8-1:0]   in_rsp_data,
    output logic [IN_TAG_WIDTH-1:0]  in_rsp_tag,
    input  logic                     in_rsp_ready,
    output logic [OUT_TAG_WIDTH:0]   pending_count,
    output logic                     err_unalloc
);

    logic [NUM_ENTRIES-1:0]   valid;
    logic [OUT_TAG_WIDTH-1:0] alloc_idx;
    logic                     full;
    logic                     is_write;
    logic                     req_ok;
    logic                     alloc_en;
    logic                     rsp_hit;
    logic                     free_en;
    logic [IN_TAG_WIDTH-1:0]  tag_table [NUM_ENTRIES];

    vx_mem_tag_compactor_tag_alloc #(
        .N (NUM_ENTRIES),
        .W (OUT_TAG_WIDTH)
    ) u_alloc (
        .clk       (clk),
        .reset     (reset),
        .alloc_en  (alloc_en),
        .free_en   (free_en),
        .free_idx  (mem_rsp_tag),
        .valid     (valid),
        .alloc_idx (alloc_idx),
        .full      (full),
        .count     (pending_count)
    );

    assign is_write = (req_kind_e'(in_req_rw) == REQ_WRITE);
    assign req_ok   = is_write | ~full;

    assign out_req_valid  = in_req_valid & req_ok;
    assign in_req_ready   = out_req_ready & req_ok;
    assign out_req_rw     = in_req_rw;
    assign out_req_addr   = in_req_addr;
    assign out_req_data   = in_req_data;
    assign out_req_byteen = in_req_byteen;
    assign out_req_tag    = is_write ? '0 : alloc_idx;
    assign alloc_en       = in_req_valid & in_req_ready & ~is_write;

    // Responses to free slots are swallowed rather than stalling the bus.
    assign rsp_hit       = valid[mem_rsp_tag];
    assign in_rsp_valid  = mem_rsp_valid & rsp_hit;
    assign in_rsp_data   = mem_rsp_data;
    assign in_rsp_tag    = tag_table[mem_rsp_tag];
    assign mem_rsp_ready = in_rsp_ready | ~rsp_hit;
    assign free_en       = in_rsp_valid & in_rsp_ready;

    always_ff @(posedge clk) begin
        if (alloc_en)
            tag_table[alloc_idx] <= in_req_tag;
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_unalloc <= 1'b0;
        else if (mem_rsp_valid & ~rsp_hit)
            err_unalloc <= 1'b1;
    end

`ifdef MEM_TAG_COMPACT_PERF_EN
    mem_tag_compact_perf_t perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            if (in_req_valid && !is_write && full && perf_q.stall_cycles != '1)
                perf_q.stall_cycles <= perf_q.stall_cycles + 1'b1;
            if (PERF_W'(pending_count) > perf_q.peak_pending)
                perf_q.peak_pending <= PERF_W'(pending_count);
        end
    end

    assign perf_stall_cycles = perf_q.stall_cycles;
    assign perf_peak_pending = perf_q.peak_pending;
`endif

endmodule
